mul8x8_seq: RTL and testbench

//  Sequential 8x8 unsigned multiplier built around one mul4x4 core.
//  - Accepts an operand pair over a valid/ready handshake.
//  - Feeds the four nibble pairs through the 4x4 core, one pair per cycle.
//  - Accumulates the shifted partial products into a 16-bit result.
//  - Presents the result over a valid/ready handshake to the ALU result mux.
//  - Gives the CPU a full byte multiply while instantiating only one 4x4 array.

---
 rtl/mul_pkg.sv | 36 +++
 rtl/mul4x4.sv | 16 +
 rtl/mul8x8_seq.sv | 100 ++++++++++
 tb/tb_mul8x8_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul_pkg
// Brief  : FSM encodings, step width and nibble-select/shift table.
// Rev    : 1.0
// ============================================================================
package mul_pkg;

    localparam int STEP_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       a_hi;
        logic       b_hi;
        logic [3:0] shift;
    } step_sel_t;

    // Partial-product order: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic step_sel_t step_sel(input logic [STEP_W-1:0] step);
        step_sel_t sel;
        case (step)
            2'd0:    sel = '{a_hi: 1'b0, b_hi: 1'b0, shift: 4'd0};
            2'd1:    sel = '{a_hi: 1'b1, b_hi: 1'b0, shift: 4'd4};
            2'd2:    sel = '{a_hi: 1'b0, b_hi: 1'b1, shift: 4'd4};
            default: sel = '{a_hi: 1'b1, b_hi: 1'b1, shift: 4'd8};
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul4x4.sv
`default_nettype none
// ============================================================================
// Module : mul4x4
// Brief  : Purely combinational 4x4 unsigned multiplier core.
// Rev    : 1.0
// ============================================================================
module mul4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'd0, a} * {4'd0, b};

endmodule
`default_nettype wire

// File: rtl/mul8x8_seq.sv
`default_nettype none
// ============================================================================
// Module : mul8x8_seq
// Brief  : 8x8 unsigned multiplier, four nibble passes through one 4x4 core.
// Rev    : 1.0
// ============================================================================
module mul8x8_seq
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [7:0]          r_op_a;
    logic [7:0]          r_op_b;
    logic [15:0]         r_acc;
    logic                r_out_valid;
    logic                r_busy;

    step_sel_t           w_sel;
    logic [3:0]          w_nib_a;
    logic [3:0]          w_nib_b;
    logic [7:0]          w_pp;
    logic [15:0]         w_pp_shifted;
    logic [15:0]         w_acc_next;

    assign w_sel        = step_sel(r_step);
    assign w_nib_a      = w_sel.a_hi ? r_op_a[7:4] : r_op_a[3:0];
    assign w_nib_b      = w_sel.b_hi ? r_op_b[7:4] : r_op_b[3:0];
    assign w_pp_shifted = {8'd0, w_pp} << w_sel.shift;
    assign w_acc_next   = r_acc + w_pp_shifted;

    mul4x4 u_core (
        .a (w_nib_a),
        .b (w_nib_b),
        .p (w_pp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_CALC;
                        r_op_a  <= in_a;
                        r_op_b  <= in_b;
                        r_acc   <= '0;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + STEP_W'(1);
                    if (r_step == STEP_W'(3)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) & ~reset;
    assign out_res   = r_acc;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul8x8_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_mul8x8_seq
// Brief  : Directed self-checking bench for mul8x8_seq.
// Rev    : 1.0
// ============================================================================
module tb_mul8x8_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_res;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul8x8_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_res   (out_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Presents one pair for a single edge, then waits (bounded) for out_valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] res, output int lat);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        lat = lat - 1;
        if (!out_valid) lat = -1;
        res = out_res;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_res !== 16'h0000) begin errors++; $display("FAIL reset_out_res got=%h exp=0000", out_res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] res;
        int lat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (k == 4)) begin errors++; $display("FAIL basic_latency cycle=%0d out_valid=%b exp=%b", k, out_valid, (k == 4)); end
        end
        checks++; if (out_res !== 16'h03A8) begin errors++; $display("FAIL basic_res got=%h exp=03a8", out_res); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
        res = '0; lat = 0;
    endtask

    task automatic test_corners();
        logic [7:0]  va [3] = '{8'hFF, 8'h00, 8'h01};
        logic [7:0]  vb [3] = '{8'hFF, 8'hA5, 8'h80};
        logic [15:0] ve [3] = '{16'hFE01, 16'h0000, 16'h0080};
        logic [15:0] res;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], res, lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL corner_lat[%0d] got=%0d exp=4", i, lat); end
            checks++; if (res !== ve[i]) begin errors++; $display("FAIL corner_res[%0d] got=%h exp=%h", i, res, ve[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        int lat;
        int bad;
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, res, lat);
        checks++; if (lat != 4 || res !== 16'h03A8) begin errors++; $display("FAIL bp_first lat=%0d res=%h exp 4/03a8", lat, res); end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            in_a = 8'h77; in_b = 8'h99; in_valid = k[0];
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_res !== 16'h03A8 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d exp=0 out_res=%h", bad, out_res); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
        do_op(8'h0F, 8'h0F, res, lat);
        checks++; if (lat != 4 || res !== 16'h00E1) begin errors++; $display("FAIL bp_next lat=%0d res=%h exp 4/00e1", lat, res); end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_latch();
        int lat;
        out_ready = 1'b1;
        in_a = 8'h0F; in_b = 8'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'hFF; in_b = 8'hFF;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (out_valid !== 1'b1 || out_res !== 16'h00F0) begin errors++; $display("FAIL latch_res got=%h valid=%b exp=00f0", out_res, out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [15:0] res;
        int lat;
        int rose;
        out_ready = 1'b1;
        in_a = 8'hAB; in_b = 8'hCD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_res !== 16'h0000 || in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_immediate valid=%b busy=%b res=%h in_ready=%b exp 0/0/0000/0", out_valid, busy, out_res, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rose = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        checks++; if (rose != 0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_no_result rose=%0d in_ready=%b exp 0/1", rose, in_ready); end
        do_op(8'h03, 8'h05, res, lat);
        checks++; if (lat != 4 || res !== 16'h000F) begin errors++; $display("FAIL abort_next lat=%0d res=%h exp 4/000f", lat, res); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_operand_latch();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
